// File: rtl/cache_fill_if.sv
// Cache fill bundle: CPU miss request, backing memory read port and
// data/tag array write port, seen from the fill FSM (master) side.
interface cache_fill_if #(
  parameter int BLOCK_WORDS = 8
);
  localparam int OFS_W = $clog2(BLOCK_WORDS) + 1;

  logic             miss_detected;
  logic [15:0]      miss_address;
  logic [15:0]      memory_data;
  logic             memory_data_valid;
  logic             fsm_busy;
  logic             mem_en;
  logic [15:0]      memory_address;
  logic             write_data_array;
  logic [OFS_W-2:0] word_sel;
  logic [15:0]      cache_data_out;
  logic             write_tag_array;
  logic             fill_done;

  modport master (
    input  miss_detected,
    input  miss_address,
    input  memory_data,
    input  memory_data_valid,
    output fsm_busy,
    output mem_en,
    output memory_address,
    output write_data_array,
    output word_sel,
    output cache_data_out,
    output write_tag_array,
    output fill_done
  );

  modport slave (
    output miss_detected,
    output miss_address,
    output memory_data,
    output memory_data_valid,
    input  fsm_busy,
    input  mem_en,
    input  memory_address,
    input  write_data_array,
    input  word_sel,
    input  cache_data_out,
    input  write_tag_array,
    input  fill_done
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache block fill engine: issues BLOCK_WORDS back-to-back reads and
// writes returning beats into the data array, then writes the tag.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  cache_fill_if.master bus
);
  localparam int OFS_W = $clog2(BLOCK_WORDS) + 1;
  localparam logic [OFS_W-1:0] NWORDS = OFS_W'(BLOCK_WORDS);
  localparam logic [OFS_W-1:0] LAST = OFS_W'(BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t           state, state_nx;
  logic [OFS_W-1:0] issue_cnt, issue_nx;
  logic [OFS_W-1:0] recv_cnt, recv_nx;
  logic [15:0]      base, base_nx;

  // State, counters and latched block base
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
    end else begin
      state     <= state_nx;
      issue_cnt <= issue_nx;
      recv_cnt  <= recv_nx;
      base      <= base_nx;
    end
  end

  // Next state plus request/write strobes; beats are counted, not timed
  always_comb begin
    state_nx             = state;
    issue_nx             = issue_cnt;
    recv_nx              = recv_cnt;
    base_nx              = base;
    bus.fsm_busy         = 1'b0;
    bus.mem_en           = 1'b0;
    bus.memory_address   = 16'h0000;
    bus.write_data_array = 1'b0;
    bus.word_sel         = '0;
    bus.cache_data_out   = 16'h0000;
    bus.write_tag_array  = 1'b0;
    bus.fill_done        = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.miss_detected) begin
          state_nx = FILL;
          base_nx  = {bus.miss_address[15:OFS_W], {OFS_W{1'b0}}};
          issue_nx = '0;
          recv_nx  = '0;
        end
      end
      FILL: begin
        bus.fsm_busy = 1'b1;
        if (issue_cnt < NWORDS) begin
          bus.mem_en         = 1'b1;
          bus.memory_address = base | 16'({issue_cnt, 1'b0});
          issue_nx           = issue_cnt + 1'b1;
        end
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          bus.word_sel         = recv_cnt[OFS_W-2:0];
          bus.cache_data_out   = bus.memory_data;
          recv_nx              = recv_cnt + 1'b1;
          if (recv_cnt == LAST) begin
            bus.write_tag_array = 1'b1;
            bus.fill_done       = 1'b1;
            state_nx            = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous, active-high reset named rst.
REQ-002 Parameter BLOCK_WORDS SHALL default to 8 and set the 16-bit words per cache block; legal values are 2, 4 and 8.
REQ-003 Localparam OFS_W SHALL equal log2(BLOCK_WORDS)+1 and is the byte-offset width within a block.
REQ-004 Port clk SHALL be an input, 1 bit wide: the system clock, rising edge active.
REQ-005 Port rst SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-006 Port miss_detected SHALL be an input, 1 bit wide: cache miss request from the CPU memory stage.
REQ-007 Port miss_address SHALL be an input, 16 bits wide: byte address of the missing access.
REQ-008 Port memory_data SHALL be an input, 16 bits wide: read data from backing memory.
REQ-009 Port memory_data_valid SHALL be an input, 1 bit wide: memory_data is valid this cycle.
REQ-010 Port fsm_busy SHALL be an output, 1 bit wide: a fill is in progress, and the CPU stalls while it is high.
REQ-011 Port mem_en SHALL be an output, 1 bit wide: a memory read request is issued this cycle.
REQ-012 Port memory_address SHALL be an output, 16 bits wide: byte address of the read being issued.
REQ-013 Port write_data_array SHALL be an output, 1 bit wide: write cache_data_out into the data array.
REQ-014 Port word_sel SHALL be an output, OFS_W-1 bits wide: word index within the block for the data-array write.
REQ-015 Port cache_data_out SHALL be an output, 16 bits wide: data for the data-array write.
REQ-016 Port write_tag_array SHALL be an output, 1 bit wide: write the tag and valid bit for the latched block.
REQ-017 Port fill_done SHALL be an output, 1 bit wide: one-cycle pulse when the fill completes.

Function
REQ-018 The block SHALL implement two registered states, IDLE and FILL.
REQ-019 IDLE to FILL SHALL occur on a rising edge where the state is IDLE and miss_detected=1.
- At that edge: latch the block base {miss_address[15:OFS_W], OFS_W'b0}; clear issue_cnt and recv_cnt.
REQ-020 fsm_busy SHALL equal (state==FILL), registered, with no combinational path from miss_detected.
REQ-021 In FILL, mem_en SHALL be 1 while issue_cnt<BLOCK_WORDS; issue_cnt increments each such cycle.
- This gives exactly BLOCK_WORDS back-to-back requests.
REQ-022 memory_address SHALL equal base | {issue_cnt, 1'b0} while mem_en=1, and 16'h0000 otherwise.
REQ-023 In FILL, each cycle with memory_data_valid=1 SHALL do the following:
- drive write_data_array=1;
- drive word_sel=recv_cnt;
- drive cache_data_out=memory_data;
- increment recv_cnt.
REQ-024 Valid beats SHALL be counted, not timed, so that any memory latency ≥1 cycle and gaps between beats are tolerated.
REQ-025 On the beat where recv_cnt==BLOCK_WORDS-1, the block SHALL assert write_tag_array=1 and fill_done=1 in the same cycle.
- Next state: IDLE.
REQ-026 memory_data_valid in IDLE SHALL be ignored: no writes and no counter change.
REQ-027 miss_detected while in FILL SHALL be ignored; the CPU re-presents the miss after fsm_busy falls.
REQ-028 miss_detected in the cycle fsm_busy falls (first IDLE cycle) SHALL start a new fill at that edge.
REQ-029 Outside REQ-021 and REQ-023, mem_en, write_data_array, write_tag_array and fill_done SHALL be 0, and word_sel and cache_data_out SHALL be 0.
REQ-030 Counters SHALL be log2(BLOCK_WORDS)+1 bits wide and SHALL NOT wrap within a fill.

Reset
REQ-031 rst=1 at a rising edge SHALL force IDLE, clear issue_cnt, recv_cnt and the latched base, and make all outputs 0 the following cycle.
REQ-032 rst SHALL take priority over miss_detected and memory_data_valid in the same cycle.
REQ-033 Reset mid-fill SHALL abandon the fill with no write_tag_array; late memory_data_valid beats after reset are ignored.

Verification
REQ-034 Basic fill with a 4-cycle memory model: miss_detected=1 with miss_address=16'h1236 at cycle N.
- Required: fsm_busy=1 from N+1 to N+12.
- Required: mem_en in cycles N+1..N+8, addresses 16'h1230, 1232, …, 123E.
- Required: write_data_array in N+5..N+12 with word_sel 0..7.
- Required: write_tag_array=1 and fill_done=1 in N+12 only; fsm_busy=0 at N+13.
REQ-035 Gapped returns: valid beats separated by 0–3 idle cycles.
- Required: exactly 8 data writes in word order, then one tag write, regardless of timing.
REQ-036 Ignored miss: miss_detected held high for the entire fill.
- Required: one fill only, with a second fill starting at the first IDLE edge.
REQ-037 Reset mid-fill: rst=1 after the third beat.
- Required: all outputs 0 the next cycle and no tag write.
- Required: 5 further valid beats produce no writes.
REQ-038 Stray valid: memory_data_valid=1 while in IDLE.
- Required: no write_data_array and fsm_busy stays 0.
REQ-039 With BLOCK_WORDS=4 and miss_address=16'hFFFF, the block SHALL issue addresses FFF8, FFFA, FFFC, FFFE and assert tag on the 4th beat.
